mult_exec_unit: RTL and testbench



---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_pipe_stage.sv | 28 ++
 rtl/mult_exec_unit.sv | 79 +++++++
 tb/tb_mult_exec_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths, pipeline entry type and saturation helper for the multiply execution unit.
package mult_pkg;

    localparam int unsigned MULT_DATA_W = 16;
    localparam int unsigned MULT_TAG_W  = 5;
    localparam int unsigned MULT_STAGES = 4;

    typedef struct packed {
        logic                     valid;
        logic [MULT_TAG_W-1:0]    tag;
        logic [2*MULT_DATA_W-1:0] prod;
    } mult_entry_t;

    // In range when the top DATA_W+1 bits are all copies of the sign bit.
    function automatic logic [MULT_DATA_W-1:0] sat_to_data(input logic [2*MULT_DATA_W-1:0] prod);
        logic [MULT_DATA_W:0] upper;
        upper = prod[2*MULT_DATA_W-1:MULT_DATA_W-1];
        if ((&upper) || (~|upper)) begin
            return prod[MULT_DATA_W-1:0];
        end else if (prod[2*MULT_DATA_W-1]) begin
            return {1'b1, {(MULT_DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(MULT_DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One pipeline register slice of the multiply unit: hold on ~i_en, drop valid on i_flush.
module mult_pipe_stage
    import mult_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_flush,
    input  mult_entry_t i_entry,
    output mult_entry_t o_entry
);

    mult_entry_t r_entry;

    // Flush only kills the valid bit; a frozen stage is still squashed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_entry <= '0;
        end else if (i_flush) begin
            r_entry.valid <= 1'b0;
        end else if (i_en) begin
            r_entry <= i_entry;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/mult_exec_unit.sv
// Pipelined signed multiply unit with CDB request/grant output and flush.
// Define MULT_SAT_EN to clamp results to the signed DATA_W range instead of truncating.
module mult_exec_unit
    import mult_pkg::*;
#(
    parameter int unsigned DATA_W = MULT_DATA_W,
    parameter int unsigned TAG_W  = MULT_TAG_W,
    parameter int unsigned STAGES = MULT_STAGES
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              IssueQue_Ready,
    input  logic [DATA_W-1:0] IssueQue_Rs_Data,
    input  logic [DATA_W-1:0] IssueQue_Rt_Data,
    input  logic [TAG_W-1:0]  IssueQue_Rd_Tag,
    output logic              Mult_Issue,
    output logic              Mult_Busy,
    output logic              Mult_Cdb_Req,
    output logic [TAG_W-1:0]  Mult_Cdb_Tag,
    output logic [DATA_W-1:0] Mult_Cdb_Data,
    input  logic              Cdb_Grant,
    input  logic              RB_Flush_Valid
);

    mult_entry_t         w_stage_in  [STAGES];
    mult_entry_t         w_stage_out [STAGES];
    logic [STAGES-1:0]   w_valid;
    logic                w_stall;
    logic [2*DATA_W-1:0] w_rs_ext;
    logic [2*DATA_W-1:0] w_rt_ext;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_unused_prod_hi;

    assign w_stall = w_stage_out[STAGES-1].valid & ~Cdb_Grant;

    // Rst_n gating keeps the queue from popping while the pipe is held in reset.
    assign Mult_Issue = IssueQue_Ready & ~w_stall & ~RB_Flush_Valid & Rst_n;

    // Low 2*DATA_W bits of the product are sign-correct once both operands are extended.
    assign w_rs_ext  = {{DATA_W{IssueQue_Rs_Data[DATA_W-1]}}, IssueQue_Rs_Data};
    assign w_rt_ext  = {{DATA_W{IssueQue_Rt_Data[DATA_W-1]}}, IssueQue_Rt_Data};
    assign w_product = w_rs_ext * w_rt_ext;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_stage_in[k] = '{valid: Mult_Issue, tag: IssueQue_Rd_Tag, prod: w_product};
        end else if (k == STAGES - 1) begin : g_tail
`ifdef MULT_SAT_EN
            logic [DATA_W-1:0] w_sat;
            assign w_sat = sat_to_data(w_stage_out[k-1].prod);
            assign w_stage_in[k] = '{valid: w_stage_out[k-1].valid,
                                     tag:   w_stage_out[k-1].tag,
                                     prod:  {{DATA_W{w_sat[DATA_W-1]}}, w_sat}};
`else
            assign w_stage_in[k] = w_stage_out[k-1];
`endif
        end else begin : g_mid
            assign w_stage_in[k] = w_stage_out[k-1];
        end

        mult_pipe_stage u_stage (
            .i_clk   (Clk),
            .i_rst_n (Rst_n),
            .i_en    (~w_stall),
            .i_flush (RB_Flush_Valid),
            .i_entry (w_stage_in[k]),
            .o_entry (w_stage_out[k])
        );

        assign w_valid[k] = w_stage_out[k].valid;
    end

    assign Mult_Busy        = |w_valid;
    assign Mult_Cdb_Req     = w_stage_out[STAGES-1].valid & ~RB_Flush_Valid;
    assign Mult_Cdb_Tag     = w_stage_out[STAGES-1].tag;
    assign Mult_Cdb_Data    = w_stage_out[STAGES-1].prod[DATA_W-1:0];
    assign w_unused_prod_hi = w_stage_out[STAGES-1].prod[2*DATA_W-1:DATA_W];

endmodule

// File: tb/tb_mult_exec_unit.sv
// Scoreboard bench for mult_exec_unit: expected {tag, data} queued on issue, checked on grant.
module tb_mult_exec_unit;

    localparam int DW = 16;
    localparam int TW = 5;
    localparam int ST = 4;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          IssueQue_Ready;
    logic [DW-1:0] IssueQue_Rs_Data;
    logic [DW-1:0] IssueQue_Rt_Data;
    logic [TW-1:0] IssueQue_Rd_Tag;
    logic          Mult_Issue;
    logic          Mult_Busy;
    logic          Mult_Cdb_Req;
    logic [TW-1:0] Mult_Cdb_Tag;
    logic [DW-1:0] Mult_Cdb_Data;
    logic          Cdb_Grant;
    logic          RB_Flush_Valid;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pops  = 0;
    int   p0;

    always #5 Clk = ~Clk;

    mult_exec_unit #(
        .DATA_W (DW),
        .TAG_W  (TW),
        .STAGES (ST)
    ) u_dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .IssueQue_Ready   (IssueQue_Ready),
        .IssueQue_Rs_Data (IssueQue_Rs_Data),
        .IssueQue_Rt_Data (IssueQue_Rt_Data),
        .IssueQue_Rd_Tag  (IssueQue_Rd_Tag),
        .Mult_Issue       (Mult_Issue),
        .Mult_Busy        (Mult_Busy),
        .Mult_Cdb_Req     (Mult_Cdb_Req),
        .Mult_Cdb_Tag     (Mult_Cdb_Tag),
        .Mult_Cdb_Data    (Mult_Cdb_Data),
        .Cdb_Grant        (Cdb_Grant),
        .RB_Flush_Valid   (RB_Flush_Valid)
    );

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int          p;
        logic [31:0] pv;
        p = int'($signed(a)) * int'($signed(b));
`ifdef MULT_SAT_EN
        if (p > 32767) return 16'h7FFF;
        if (p < -32768) return 16'h8000;
`endif
        pv = p;
        return pv[DW-1:0];
    endfunction

    // Observe combinational handshake mid-cycle, well away from the rising edge.
    always @(negedge Clk) begin
        exp_t e;
        if (Rst_n) begin
            if (Mult_Cdb_Req && Cdb_Grant) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    n_pops++;
                    check_eq("cdb_tag", Mult_Cdb_Tag, e.tag);
                    check_eq("cdb_data", Mult_Cdb_Data, e.data);
                end
            end
            if (Mult_Issue) exp_q.push_back('{IssueQue_Rd_Tag, model(IssueQue_Rs_Data, IssueQue_Rt_Data)});
            if (RB_Flush_Valid) exp_q.delete();
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_op(input logic rdy, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [TW-1:0] t);
        IssueQue_Ready   = rdy;
        IssueQue_Rs_Data = a;
        IssueQue_Rt_Data = b;
        IssueQue_Rd_Tag  = t;
    endtask

    // Call in the issue cycle; checks Req rises exactly ST cycles later with the given result.
    task automatic expect_latency(input string name, input logic [TW-1:0] t, input logic [DW-1:0] d);
        step();
        IssueQue_Ready = 1'b0;
        for (int i = 0; i < ST - 1; i++) begin
            #1;
            check_eq({name, "_req_early"}, Mult_Cdb_Req, 0);
            step();
        end
        #1;
        check_eq({name, "_req"}, Mult_Cdb_Req, 1);
        check_eq({name, "_tag"}, Mult_Cdb_Tag, t);
        check_eq({name, "_data"}, Mult_Cdb_Data, d);
    endtask

    task automatic drain(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
        check_eq(name, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst_n          = 1'b0;
        Cdb_Grant      = 1'b0;
        RB_Flush_Valid = 1'b0;
        drive_op(1'b1, '0, '0, '0);

        // Reset state, with Ready high to confirm no issue leaks through.
        repeat (2) @(posedge Clk);
        #3;
        check_eq("rst_issue", Mult_Issue, 0);
        check_eq("rst_busy", Mult_Busy, 0);
        check_eq("rst_req", Mult_Cdb_Req, 0);
        check_eq("rst_tag", Mult_Cdb_Tag, 0);
        check_eq("rst_data", Mult_Cdb_Data, 0);
        IssueQue_Ready = 1'b0;
        Rst_n = 1'b1;
        step();

        // 1: single op, 3 * -5.
        drive_op(1'b1, 16'd3, 16'hFFFB, 5'd7);
        #1;
        check_eq("t1_issue", Mult_Issue, 1);
        expect_latency("t1", 5'd7, 16'hFFF1);
        Cdb_Grant = 1'b1;
        step();
        #1;
        check_eq("t1_req_drop", Mult_Cdb_Req, 0);
        check_eq("t1_sb", exp_q.size(), 0);
        Cdb_Grant = 1'b0;

        // 2: six back-to-back ops with grant held.
        Cdb_Grant = 1'b1;
        p0 = n_pops;
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b1, 16'($urandom), 16'($urandom), TW'(i + 1));
            #1;
            check_eq("t2_issue", Mult_Issue, 1);
            step();
        end
        IssueQue_Ready = 1'b0;
        repeat (4) step();
        check_eq("t2_pops", n_pops - p0, 6);
        check_eq("t2_sb", exp_q.size(), 0);

        // 3: fill the pipe with grant low, hold 5 cycles, then release.
        Cdb_Grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b1, 16'($urandom), 16'($urandom), TW'(8 + i));
            #1;
            check_eq("t3_fill_issue", Mult_Issue, 1);
            step();
        end
        drive_op(1'b1, 16'($urandom), 16'($urandom), 5'd12);
        p0 = n_pops;
        for (int j = 0; j < 5; j++) begin
            #1;
            check_eq("t3_stall_issue", Mult_Issue, 0);
            check_eq("t3_stall_req", Mult_Cdb_Req, 1);
            check_eq("t3_stall_tag", Mult_Cdb_Tag, exp_q[0].tag);
            check_eq("t3_stall_data", Mult_Cdb_Data, exp_q[0].data);
            step();
        end
        Cdb_Grant = 1'b1;
        #1;
        check_eq("t3_issue_on_grant", Mult_Issue, 1);
        step();
        IssueQue_Ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check_eq("t3_b2b_req", Mult_Cdb_Req, 1);
            step();
        end
        drain("t3_drain", 10);
        check_eq("t3_pops", n_pops - p0, 5);

        // 4: flush in the same cycle as Req & Grant with three more ops behind it.
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b1, 16'($urandom), 16'($urandom), TW'(16 + i));
            #1;
            check_eq("t4_fill_issue", Mult_Issue, 1);
            step();
        end
        RB_Flush_Valid = 1'b1;
        drive_op(1'b1, 16'd5, 16'd5, 5'd20);
        #1;
        check_eq("t4_req_masked", Mult_Cdb_Req, 0);
        check_eq("t4_issue_masked", Mult_Issue, 0);
        step();
        RB_Flush_Valid = 1'b0;
        IssueQue_Ready = 1'b0;
        #1;
        check_eq("t4_busy", Mult_Busy, 0);
        check_eq("t4_req", Mult_Cdb_Req, 0);
        drive_op(1'b1, 16'h0100, 16'hFFFF, 5'd21);
        #1;
        check_eq("t4_reissue", Mult_Issue, 1);
        expect_latency("t4", 5'd21, 16'hFF00);
        step();
        check_eq("t4_sb", exp_q.size(), 0);

        // 5: overflow and most-negative operand.
        drive_op(1'b1, 16'd300, 16'd300, 5'd22);
        #1;
        check_eq("t5_issue", Mult_Issue, 1);
        step();
        drive_op(1'b1, 16'h8000, 16'd1, 5'd23);
        step();
        IssueQue_Ready = 1'b0;
        drain("t5_drain", 10);

        // 6: asynchronous reset while a request is pending.
        Cdb_Grant = 1'b0;
        drive_op(1'b1, 16'($urandom), 16'($urandom), 5'd24);
        step();
        drive_op(1'b1, 16'($urandom), 16'($urandom), 5'd25);
        step();
        IssueQue_Ready = 1'b0;
        for (int i = 0; i < 10 && !Mult_Cdb_Req; i++) step();
        check_eq("t6_req_before", Mult_Cdb_Req, 1);
        #2;
        Rst_n = 1'b0;
        IssueQue_Ready = 1'b1;
        exp_q.delete();
        #1;
        check_eq("t6_rst_issue", Mult_Issue, 0);
        check_eq("t6_rst_busy", Mult_Busy, 0);
        check_eq("t6_rst_req", Mult_Cdb_Req, 0);
        check_eq("t6_rst_tag", Mult_Cdb_Tag, 0);
        check_eq("t6_rst_data", Mult_Cdb_Data, 0);
        @(posedge Clk);
        #3;
        IssueQue_Ready = 1'b0;
        Rst_n = 1'b1;
        step();
        drive_op(1'b1, 16'h7FFF, 16'd2, 5'd26);
        #1;
        check_eq("t6_issue", Mult_Issue, 1);
        expect_latency("t6", 5'd26, model(16'h7FFF, 16'd2));
        Cdb_Grant = 1'b1;
        step();
        Cdb_Grant = 1'b0;
        #1;
        check_eq("t6_req_drop", Mult_Cdb_Req, 0);
        check_eq("t6_sb", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
